// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract engine:
// FSM state encoding and the default operand width.
package serial_alu_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Start/done handshake and operand/result bus between the sequencer
// (master) and the bit-serial engine (slave).
interface serial_add_ctrl_if #(
    parameter int WIDTH = serial_alu_pkg::DEF_WIDTH
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_add_ctrl_bit_full_adder.sv
// Single-bit full-adder cell, reused every cycle by the serial engine.
module bit_full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract: one full-adder cell iterated WIDTH cycles, LSB
// first, with a carry FF and operand/result shift registers around it.
module serial_add_ctrl
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic            clk,
    input  logic            rst,
    serial_add_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t           state, state_nx;
    logic [WIDTH-1:0] op_a, op_b, sum_q;
    // Only the upper WIDTH-1 result bits need storage; the last cell
    // output completes the word directly into sum_q.
    logic [WIDTH-2:0] res;
    logic [WIDTH-1:0] res_full;
    logic [CNT_W-1:0] cnt;
    logic             carry, c_msb, cout_q, ovf_q;
    logic             s, co, last;

    bit_full_adder u_fa (
        .a  (op_a[0]),
        .b  (op_b[0]),
        .ci (carry),
        .s  (s),
        .co (co)
    );

    assign last     = (cnt == CNT_W'(WIDTH - 1));
    assign res_full = {s, res};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: state_nx = bus.start ? RUN : IDLE;
            RUN:        if (last) state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_a   <= '0;
            op_b   <= '0;
            res    <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            c_msb  <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    // Subtract as a + ~b + 1: invert B and seed the carry.
                    if (bus.start) begin
                        op_a  <= bus.a;
                        op_b  <= bus.sub ? ~bus.b : bus.b;
                        carry <= bus.sub;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    op_a  <= op_a >> 1;
                    op_b  <= op_b >> 1;
                    res   <= res_full[WIDTH-1:1];
                    carry <= co;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 2)) c_msb <= co;
                    if (last) begin
                        sum_q  <= res_full;
                        cout_q <= co;
                        ovf_q  <= c_msb ^ co;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): directed vector table,
// hand-written handshake corner cases, and randomized ops vs. an arithmetic model.
module tb_serial_add_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    serial_add_ctrl_if #(.WIDTH(W)) bus ();

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         sub;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    task automatic model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] rs, output logic rc, output logic ro);
        int unsigned full;
        int          sx, sy, r;
        sx = $signed(x);
        sy = $signed(y);
        r  = s ? sx - sy : sx + sy;
        ro = (r > 127) || (r < -128);
        full = s ? (32'(x) + 256 - 32'(y)) : (32'(x) + 32'(y));
        rs = full[W-1:0];
        rc = s ? (x >= y) : (full > 255);
    endtask

    // One op: start sampled at edge E; returns edges from E to done and
    // the number of busy samples seen (from E up to, not including, done).
    task automatic run_op(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                          output logic [W-1:0] rs, output logic rc, output logic ro,
                          output int lat, output int bcnt);
        @(negedge clk);
        bus.start = 1'b1; bus.sub = s; bus.a = x; bus.b = y;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a = W'($urandom); bus.b = W'($urandom); bus.sub = ~s;
        lat = -1; bcnt = 0;
        if (bus.busy) bcnt++;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (bus.done) begin lat = n; break; end
            if (bus.busy) bcnt++;
        end
        rs = bus.sum; rc = bus.cout; ro = bus.ovf;
    endtask

    initial begin
        logic [W-1:0] rs, es;
        logic         rc, ro, ec, eo;
        int           lat, bcnt, nd;
        int           t[2];
        logic [W-1:0] ts[2];
        logic         to[2];

        vecs[0] = '{1'b0, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};

        rst = 1'b1; bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_sum",  32'(bus.sum),  0);
        chk("rst_cout", 32'(bus.cout), 0);
        chk("rst_ovf",  32'(bus.ovf),  0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].sub, vecs[i].a, vecs[i].b, rs, rc, ro, lat, bcnt);
            chk($sformatf("vec%0d_lat", i),  32'(lat),  32'(W));
            chk($sformatf("vec%0d_busy", i), 32'(bcnt), 32'(W));
            chk($sformatf("vec%0d_sum", i),  32'(rs),   32'(vecs[i].exp_sum));
            chk($sformatf("vec%0d_cout", i), 32'(rc),   32'(vecs[i].exp_cout));
            chk($sformatf("vec%0d_ovf", i),  32'(ro),   32'(vecs[i].exp_ovf));
        end

        // Start pulsed mid-RUN must be ignored.
        @(negedge clk);
        bus.start = 1'b1; bus.sub = 1'b0; bus.a = 8'h5A; bus.b = 8'h3C;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.a = 8'h00; bus.b = 8'h00;
        @(posedge clk); #1;
        bus.start = 1'b0;
        nd = 0; rs = '0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (bus.done) begin nd++; rs = bus.sum; end
        end
        chk("ign_ndone", 32'(nd), 1);
        chk("ign_sum",   32'(rs), 32'h96);

        // Reset in the middle of RUN aborts with no done pulse.
        @(negedge clk);
        bus.start = 1'b1; bus.sub = 1'b0; bus.a = 8'h11; bus.b = 8'h22;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_done", 32'(bus.done), 0);
        chk("abort_sum",  32'(bus.sum),  0);
        chk("abort_cout", 32'(bus.cout), 0);
        chk("abort_ovf",  32'(bus.ovf),  0);
        nd = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (bus.done) nd++;
        end
        chk("abort_ndone", 32'(nd), 0);

        // Start held high: back-to-back ops, done every W+1 cycles.
        @(negedge clk);
        bus.start = 1'b1; bus.sub = 1'b0; bus.a = 8'h01; bus.b = 8'h01;
        @(posedge clk); #1;
        bus.a = 8'h7F; bus.b = 8'h01;
        nd = 0; t[0] = -1; t[1] = -1; ts[0] = '0; ts[1] = '0; to[0] = 1'b0; to[1] = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (bus.done && nd < 2) begin
                t[nd] = n; ts[nd] = bus.sum; to[nd] = bus.ovf; nd++;
                if (nd == 2) begin bus.start = 1'b0; break; end
            end
        end
        bus.start = 1'b0;
        chk("b2b_t0",   32'(t[0]), 32'(W));
        chk("b2b_gap",  32'(t[1] - t[0]), 32'(W + 1));
        chk("b2b_sum0", 32'(ts[0]), 32'h02);
        chk("b2b_sum1", 32'(ts[1]), 32'h80);
        chk("b2b_ovf0", 32'(to[0]), 0);
        chk("b2b_ovf1", 32'(to[1]), 1);
        @(posedge clk); #1;
        chk("b2b_idle", 32'(bus.busy | bus.done), 0);

        for (int i = 0; i < 40; i++) begin
            logic         rsub;
            logic [W-1:0] ra, rb;
            rsub = 1'($urandom);
            ra   = W'($urandom);
            rb   = W'($urandom);
            model(rsub, ra, rb, es, ec, eo);
            run_op(rsub, ra, rb, rs, rc, ro, lat, bcnt);
            chk($sformatf("rnd%0d_lat", i),  32'(lat), 32'(W));
            chk($sformatf("rnd%0d_sum", i),  32'(rs),  32'(es));
            chk($sformatf("rnd%0d_cout", i), 32'(rc),  32'(ec));
            chk($sformatf("rnd%0d_ovf", i),  32'(ro),  32'(eo));
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
